// File: rtl/sram_port_arbiter_if.sv
// Two-master request/grant bus plus the SRAM read/write port driven by the arbiter.
// The arbiter connects through the slave modport; masters and SRAM sit on the master side.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] sram_read1_addr;
  logic [DATA_W-1:0] sram_read1_data;
  logic [ADDR_W-1:0] sram_write_addr;
  logic [DATA_W-1:0] sram_write_data;
  logic              sram_write_enable;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output sram_read1_addr,
    input  sram_read1_data,
    output sram_write_addr, sram_write_data, sram_write_enable
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  sram_read1_addr,
    output sram_read1_data,
    input  sram_write_addr, sram_write_data, sram_write_enable
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter giving two masters single-cycle access to one SRAM port pair,
// with a zero-fill sequence that blocks both masters while it sweeps every word.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_port_arbiter_if.slave     bus,
  input  logic                   clr_start,
  output logic                   busy,
  output logic                   clr_done
);

  typedef enum logic {StServe, StClear} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              gnt0, gnt1, we;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StServe;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    we        = 1'b0;
    raddr     = '0;
    waddr     = '0;
    wdata     = '0;
    busy      = 1'b0;
    clr_done  = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    unique case (state_q)
      StServe: begin
        // rr_q=0 favours master 0 on contention; reset masks the combinational grants.
        gnt0 = reset & bus.m0_req & (~bus.m1_req | ~rr_q);
        gnt1 = reset & bus.m1_req & (~bus.m0_req | rr_q);
        if (gnt0) begin
          raddr     = bus.m0_addr;
          waddr     = bus.m0_addr;
          wdata     = bus.m0_wdata;
          we        = bus.m0_we;
          rvalid0_d = ~bus.m0_we;
          rr_d      = 1'b1;
        end else if (gnt1) begin
          raddr     = bus.m1_addr;
          waddr     = bus.m1_addr;
          wdata     = bus.m1_wdata;
          we        = bus.m1_we;
          rvalid1_d = ~bus.m1_we;
          rr_d      = 1'b0;
        end
        if (rvalid0_d) rdata0_d = bus.sram_read1_data;
        if (rvalid1_d) rdata1_d = bus.sram_read1_data;
        if (clr_start) state_d = StClear;
      end
      StClear: begin
        busy     = 1'b1;
        we       = 1'b1;
        waddr    = cnt_q;
        clr_done = (cnt_q == ADDR_W'(DEPTH - 1));
        if (clr_done) begin
          state_d = StServe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StServe;
    endcase
  end

  assign bus.m0_gnt            = gnt0;
  assign bus.m1_gnt            = gnt1;
  assign bus.m0_rvalid         = rvalid0_q;
  assign bus.m1_rvalid         = rvalid1_q;
  assign bus.m0_rdata          = rdata0_q;
  assign bus.m1_rdata          = rdata1_q;
  assign bus.sram_read1_addr   = raddr;
  assign bus.sram_write_addr   = waddr;
  assign bus.sram_write_data   = wdata;
  assign bus.sram_write_enable = we;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a per-cycle reference model of memory contents,
// arbitration fairness and the clear sweep, plus literal checks for the key scenarios.
module tb_sram_port_arbiter;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_start = 1'b0;
  logic busy, clr_done;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  // SRAM behind the arbiter: combinational read, write on the rising edge.
  logic [DW-1:0] sram [DEPTH] = '{default: '0};
  assign bus.sram_read1_data = sram[bus.sram_read1_addr];
  always @(posedge clk) if (bus.sram_write_enable) sram[bus.sram_write_addr] <= bus.sram_write_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what memory holds, who has priority, how many clear writes remain.
  logic [DW-1:0] mmem [DEPTH] = '{default: '0};
  int            clr_left = 0;
  int            prio = 0;
  bit            erv [2] = '{0, 0};
  logic [DW-1:0] erd [2] = '{'0, '0};

  task automatic model_cycle();
    bit            req [2];
    bit            wev [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    bit            nrv [2];
    logic [DW-1:0] nrd [2];
    int            win;
    int            ca;
    req = '{bus.m0_req, bus.m1_req};
    wev = '{bus.m0_we, bus.m1_we};
    ad  = '{bus.m0_addr, bus.m1_addr};
    wd  = '{bus.m0_wdata, bus.m1_wdata};
    if (!reset) begin
      chk("rst_gnt0", bus.m0_gnt, 0);
      chk("rst_gnt1", bus.m1_gnt, 0);
      chk("rst_we", bus.sram_write_enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", clr_done, 0);
      chk("rst_rv0", bus.m0_rvalid, 0);
      chk("rst_rv1", bus.m1_rvalid, 0);
      chk("rst_rd0", bus.m0_rdata, 0);
      chk("rst_rd1", bus.m1_rdata, 0);
      clr_left = 0;
      prio = 0;
      erv = '{0, 0};
      erd = '{'0, '0};
      return;
    end
    chk("m_rv0", bus.m0_rvalid, erv[0]);
    chk("m_rv1", bus.m1_rvalid, erv[1]);
    chk("m_rd0", bus.m0_rdata, erd[0]);
    chk("m_rd1", bus.m1_rdata, erd[1]);
    chk("m_busy", busy, clr_left > 0);
    chk("m_done", clr_done, clr_left == 1);
    nrv = '{0, 0};
    nrd = erd;
    if (clr_left > 0) begin
      ca = DEPTH - clr_left;
      chk("m_clr_gnt0", bus.m0_gnt, 0);
      chk("m_clr_gnt1", bus.m1_gnt, 0);
      chk("m_clr_we", bus.sram_write_enable, 1);
      chk("m_clr_waddr", bus.sram_write_addr, ca);
      chk("m_clr_wdata", bus.sram_write_data, 0);
      mmem[ca] = '0;
      clr_left--;
    end else begin
      win = -1;
      if (req[0] && req[1]) win = prio;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
      chk("m_gnt0", bus.m0_gnt, win == 0);
      chk("m_gnt1", bus.m1_gnt, win == 1);
      if (win >= 0 && wev[win]) begin
        chk("m_we", bus.sram_write_enable, 1);
        chk("m_waddr", bus.sram_write_addr, ad[win]);
        chk("m_wdata", bus.sram_write_data, wd[win]);
        mmem[ad[win]] = wd[win];
      end else begin
        chk("m_we_idle", bus.sram_write_enable, 0);
      end
      if (win >= 0 && !wev[win]) begin
        chk("m_raddr", bus.sram_read1_addr, ad[win]);
        nrv[win] = 1;
        nrd[win] = mmem[ad[win]];
      end
      if (win >= 0) prio = 1 - win;
      if (clr_start) clr_left = DEPTH;
    end
    erv = nrv;
    erd = nrd;
  endtask

  always @(negedge clk) model_cycle();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    clr_start = 0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = a; bus.m0_wdata = d;
    tick();
    bus.m0_req = 0; bus.m0_we = 0;
  endtask

  task automatic rd1(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = a;
    tick();
    bus.m1_req = 0;
    d = bus.m1_rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int n, done_at, gcnt;
    idle();
    repeat (3) tick();
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_we", bus.sram_write_enable, 0);
    reset = 1;
    tick();

    // m0 write then m1 read of the same word
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 5; bus.m0_wdata = 32'hDEADBEEF;
    #1 chk("lit_wr_gnt0", bus.m0_gnt, 1);
    chk("lit_wr_we", bus.sram_write_enable, 1);
    tick();
    bus.m0_req = 0; bus.m0_we = 0;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 5;
    #1 chk("lit_rd_gnt1", bus.m1_gnt, 1);
    tick();
    bus.m1_req = 0;
    #1 chk("lit_rd_rv1", bus.m1_rvalid, 1);
    chk("lit_rd_data1", bus.m1_rdata, 32'hDEADBEEF);
    tick();
    chk("lit_rv1_drop", bus.m1_rvalid, 0);
    chk("lit_rd1_hold", bus.m1_rdata, 32'hDEADBEEF);

    // continuous contention alternates m0, m1, m0, m1
    bus.m0_req = 1; bus.m0_addr = 1; bus.m1_req = 1; bus.m1_addr = 5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lit_rr_gnt0", bus.m0_gnt, (i % 2) == 0);
      chk("lit_rr_gnt1", bus.m1_gnt, (i % 2) == 1);
      if (i > 0) begin
        chk("lit_rr_rv0", bus.m0_rvalid, (i % 2) == 1);
        chk("lit_rr_rv1", bus.m1_rvalid, (i % 2) == 0);
      end
      tick();
    end
    idle();
    tick();

    // full clear sweep
    wr0(0, 32'h1);
    wr0(127, 32'h1);
    clr_start = 1;
    tick();
    clr_start = 0;
    n = 0; done_at = -1;
    while (busy && n < 200) begin
      n++;
      if (clr_done) done_at = n;
      tick();
    end
    chk("lit_clr_len", n, 128);
    chk("lit_clr_done_at", done_at, 128);
    rd1(0, d);
    chk("lit_clr_rd0", d, 0);
    rd1(127, d);
    chk("lit_clr_rd127", d, 0);

    // clr_start together with a request still grants; held request waits out the clear
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 3; clr_start = 1;
    #1 chk("lit_start_gnt0", bus.m0_gnt, 1);
    tick();
    clr_start = 0;
    n = 0; gcnt = 0;
    while (busy && n < 200) begin
      n++;
      if (bus.m0_gnt) gcnt++;
      clr_start = (n == 50);
      tick();
    end
    clr_start = 0;
    #1;
    chk("lit_restart_len", n, 128);
    chk("lit_clr_no_gnt", gcnt, 0);
    chk("lit_after_clr_gnt0", bus.m0_gnt, 1);
    tick();
    idle();
    tick();

    // reset in the middle of a clear
    wr0(10, 32'h77);
    wr0(100, 32'h55);
    clr_start = 1;
    tick();
    clr_start = 0;
    n = 0;
    while (busy && n < 60) begin
      n++;
      if (n < 60) tick();
    end
    chk("lit_abort_at", n, 60);
    reset = 0;
    #1 chk("lit_abort_busy", busy, 0);
    chk("lit_abort_we", bus.sram_write_enable, 0);
    repeat (2) tick();
    reset = 1;
    tick();
    rd1(10, d);
    chk("lit_abort_rd10", d, 0);
    rd1(100, d);
    chk("lit_abort_rd100", d, 32'h55);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
